// File: rtl/fifo_rr_arbiter.sv
// Round-robin pop controller between four source FIFOs and one destination FIFO.
// Pops are captured one cycle later and forwarded through a registered write port.
module fifo_rr_arbiter #(
    parameter int unsigned DATA_WIDTH = 4,
    parameter int unsigned BURST      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              src_empty,
    input  logic [4*DATA_WIDTH-1:0] src_data,
    output logic [3:0]              src_rd_en,
    input  logic                    dst_full,
    input  logic                    dst_almost_full,
    output logic                    dst_wr_en,
    output logic [DATA_WIDTH-1:0]   dst_data,
    output logic [1:0]              grant,
    output logic [7:0]              fwd_count
);

    typedef enum logic {StIdle, StServe} state_e;

    localparam logic [3:0] BurstMax = 4'(BURST);

    state_e                state_q, state_d;
    logic [1:0]            grant_q, grant_d;
    logic [3:0]            burst_cnt_q, burst_cnt_d;
    logic                  pend_valid_q;
    logic [1:0]            pend_src_q;
    logic                  dst_wr_en_q;
    logic [DATA_WIDTH-1:0] dst_data_q;
    logic [7:0]            fwd_count_q;

    logic                  stall;
    logic                  pop;
    logic [3:0]            cnt_inc;
    logic                  found_other;
    logic [1:0]            next_other;
    logic                  found_any;
    logic [1:0]            next_any;
    logic [1:0]            idx;
    logic [DATA_WIDTH-1:0] pend_word;

    assign stall   = dst_full | dst_almost_full;
    assign pop     = (state_q == StServe) && !src_empty[grant_q] && !stall;
    assign cnt_inc = burst_cnt_q + 4'd1;

    always_comb begin
        src_rd_en = '0;
        if (pop) begin
            src_rd_en[grant_q] = 1'b1;
        end
    end

    // Scan offsets downward so the nearest non-empty source after grant wins.
    always_comb begin
        found_other = 1'b0;
        next_other  = grant_q;
        idx         = grant_q;
        for (int k = 3; k >= 1; k--) begin
            idx = grant_q + 2'(k);
            if (!src_empty[idx]) begin
                found_other = 1'b1;
                next_other  = idx;
            end
        end
        found_any = found_other | !src_empty[grant_q];
        next_any  = found_other ? next_other : grant_q;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (found_any) begin
                    state_d     = StServe;
                    grant_d     = next_any;
                    burst_cnt_d = 4'd0;
                end
            end
            StServe: begin
                if (!stall) begin
                    if (pop) begin
                        burst_cnt_d = cnt_inc;
                    end
                    if ((pop && cnt_inc == BurstMax) || src_empty[grant_q]) begin
                        burst_cnt_d = 4'd0;
                        if (found_other) begin
                            grant_d = next_other;
                        end else if (src_empty[grant_q]) begin
                            state_d = StIdle;
                        end
                    end
                end
            end
        endcase
    end

    assign pend_word = src_data[32'(pend_src_q) * DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= StIdle;
            grant_q      <= 2'd3;
            burst_cnt_q  <= 4'd0;
            pend_valid_q <= 1'b0;
            pend_src_q   <= 2'd0;
            dst_wr_en_q  <= 1'b0;
            dst_data_q   <= '0;
            fwd_count_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            burst_cnt_q  <= burst_cnt_d;
            pend_valid_q <= pop;
            if (pop) begin
                pend_src_q <= grant_q;
            end
            // In-flight words complete regardless of stall; the destination keeps 2 spare slots.
            dst_wr_en_q <= pend_valid_q;
            if (pend_valid_q) begin
                dst_data_q  <= pend_word;
                fwd_count_q <= fwd_count_q + 8'd1;
            end
        end
    end

    assign dst_wr_en = dst_wr_en_q;
    assign dst_data  = dst_data_q;
    assign grant     = grant_q;
    assign fwd_count = fwd_count_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: source FIFOs and the arbitration rules are modelled with
// queues and integers; every cycle the DUT outputs are compared against that model.
module tb_fifo_rr_arbiter;

    localparam int DW    = 4;
    localparam int BURST = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [3:0]    src_empty;
    logic [4*DW-1:0] src_data;
    logic [3:0]    src_rd_en;
    logic          dst_full;
    logic          dst_almost_full;
    logic          dst_wr_en;
    logic [DW-1:0] dst_data;
    logic [1:0]    grant;
    logic [7:0]    fwd_count;

    fifo_rr_arbiter #(.DATA_WIDTH(DW), .BURST(BURST)) dut (
        .clk             (clk),
        .rst             (rst),
        .src_empty       (src_empty),
        .src_data        (src_data),
        .src_rd_en       (src_rd_en),
        .dst_full        (dst_full),
        .dst_almost_full (dst_almost_full),
        .dst_wr_en       (dst_wr_en),
        .dst_data        (dst_data),
        .grant           (grant),
        .fwd_count       (fwd_count)
    );

    always #5 clk = ~clk;

    // Source FIFO contents and their registered read ports.
    logic [DW-1:0] q[4][$];
    logic [DW-1:0] bout[4];

    // Reference state.
    bit            m_serve;
    int            m_g;
    int            m_cnt;
    bit            m_pend;
    int            m_psrc;
    bit            m_wr;
    logic [DW-1:0] m_data;
    int            m_fwd;
    logic [3:0]    m_rd;

    int stall_rate;
    int push_rate;
    int n_vec;
    int n_bad;

    function automatic string obs_str();
        return $sformatf("rd=%b exp %b wr=%b exp %b grant=%0d exp %0d fwd=%0d exp %0d data=%h exp %h",
                         src_rd_en, m_rd, dst_wr_en, m_wr, grant, m_g, fwd_count, m_fwd,
                         dst_data, m_data);
    endfunction

    task automatic model_reset();
        m_serve = 0; m_g = 3; m_cnt = 0; m_pend = 0; m_psrc = 0;
        m_wr = 0; m_data = '0; m_fwd = 0; m_rd = '0;
    endtask

    // Called at a falling edge: drive inputs, then work out the expected read enables.
    task automatic eval();
        if (stall_rate > 0) begin
            dst_almost_full = ($urandom_range(99) < stall_rate);
            dst_full        = ($urandom_range(99) < stall_rate / 3);
        end
        for (int i = 0; i < 4; i++) begin
            src_empty[i]          = (q[i].size() == 0);
            src_data[i*DW +: DW]  = bout[i];
        end
        #1;
        m_rd = '0;
        if (m_serve && q[m_g].size() > 0 && !(dst_full | dst_almost_full)) m_rd[m_g] = 1'b1;
    endtask

    // Step the model across one rising edge and return at the next falling edge.
    task automatic advance();
        bit e[4];
        bit stall, pop, found;
        int c, nxt;
        for (int i = 0; i < 4; i++) e[i] = (q[i].size() == 0);
        stall = dst_full | dst_almost_full;
        pop   = (m_rd != 0);
        @(posedge clk);
        m_wr = m_pend;
        if (m_pend) begin
            m_data = bout[m_psrc];
            m_fwd  = (m_fwd + 1) % 256;
        end
        m_pend = pop;
        if (pop) m_psrc = m_g;
        for (int i = 0; i < 4; i++) if (m_rd[i]) bout[i] = q[i].pop_front();
        found = 0;
        nxt   = m_g;
        if (!m_serve) begin
            for (int k = 4; k >= 1; k--) if (!e[(m_g + k) % 4]) begin found = 1; nxt = (m_g + k) % 4; end
            if (found) begin m_serve = 1; m_g = nxt; m_cnt = 0; end
        end else if (!stall) begin
            c = m_cnt + (pop ? 1 : 0);
            if ((pop && c == BURST) || e[m_g]) begin
                for (int k = 3; k >= 1; k--) if (!e[(m_g + k) % 4]) begin found = 1; nxt = (m_g + k) % 4; end
                if (found) m_g = nxt;
                else if (e[m_g]) m_serve = 0;
                m_cnt = 0;
            end else begin
                m_cnt = c;
            end
        end
        if (push_rate > 0)
            for (int i = 0; i < 4; i++)
                if (q[i].size() < 14 && $urandom_range(99) < push_rate) q[i].push_back(DW'($urandom));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        dst_full = 1'b0; dst_almost_full = 1'b0;
        stall_rate = 0; push_rate = 0;
        for (int i = 0; i < 4; i++) begin q[i].delete(); bout[i] = '0; end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) repeat (2) q[i].push_back(DW'($urandom));
        for (int c = 0; c < 3; c++) begin
            eval();
            n_vec++;
            if ({src_rd_en, dst_wr_en, grant, fwd_count} !== {4'b0, 1'b0, 2'd3, 8'd0}) begin
                n_bad++;
                $display("FAIL reset_hold cyc=%0d %s", c, obs_str());
            end
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        for (int c = 0; c < 14; c++) begin
            eval();
            n_vec++;
            if ({src_rd_en, dst_wr_en, grant, fwd_count} !== {m_rd, m_wr, 2'(m_g), 8'(m_fwd)} ||
                (m_wr && dst_data !== m_data)) begin
                n_bad++;
                $display("FAIL reset_release cyc=%0d %s", c, obs_str());
            end
            if (c == 1) begin
                n_vec++;
                if (src_rd_en !== 4'b0001) begin
                    n_bad++;
                    $display("FAIL first_pop rd=%b exp 0001", src_rd_en);
                end
            end
            advance();
        end
    endtask

    task automatic test_single_source();
        logic [DW-1:0] got[$];
        do_reset();
        q[2].push_back(4'h5); q[2].push_back(4'hA); q[2].push_back(4'h3);
        for (int c = 0; c < 9; c++) begin
            eval();
            n_vec++;
            if ({src_rd_en, dst_wr_en, grant, fwd_count} !== {m_rd, m_wr, 2'(m_g), 8'(m_fwd)} ||
                (m_wr && dst_data !== m_data)) begin
                n_bad++;
                $display("FAIL single cyc=%0d %s", c, obs_str());
            end
            if (dst_wr_en === 1'b1) got.push_back(dst_data);
            advance();
        end
        n_vec++;
        if (got.size() != 3 || got[0] !== 4'h5 || got[1] !== 4'hA || got[2] !== 4'h3 ||
            fwd_count !== 8'd3) begin
            n_bad++;
            $display("FAIL single_seq words=%0d fwd=%0d exp words=3 5,a,3 fwd=3", got.size(), fwd_count);
        end
    endtask

    task automatic test_burst_rotation();
        do_reset();
        for (int i = 0; i < 4; i++) repeat (6) q[i].push_back(DW'($urandom));
        for (int c = 0; c < 40; c++) begin
            eval();
            n_vec++;
            if ({src_rd_en, dst_wr_en, grant, fwd_count} !== {m_rd, m_wr, 2'(m_g), 8'(m_fwd)} ||
                (m_wr && dst_data !== m_data)) begin
                n_bad++;
                $display("FAIL burst cyc=%0d %s", c, obs_str());
            end
            advance();
        end
        n_vec++;
        if (fwd_count !== 8'd24) begin
            n_bad++;
            $display("FAIL burst_total fwd=%0d exp 24", fwd_count);
        end
    endtask

    task automatic test_back_pressure();
        do_reset();
        repeat (8) q[0].push_back(DW'($urandom));
        for (int c = 0; c < 16; c++) begin
            dst_almost_full = (c >= 2 && c < 6);
            eval();
            n_vec++;
            if ({src_rd_en, dst_wr_en, grant, fwd_count} !== {m_rd, m_wr, 2'(m_g), 8'(m_fwd)} ||
                (m_wr && dst_data !== m_data)) begin
                n_bad++;
                $display("FAIL backpress cyc=%0d %s", c, obs_str());
            end
            if (c == 2 || c == 3 || c == 6) begin
                n_vec++;
                if ((c == 2 && src_rd_en !== 4'b0000) || (c == 3 && dst_wr_en !== 1'b1) ||
                    (c == 6 && src_rd_en !== 4'b0001)) begin
                    n_bad++;
                    $display("FAIL backpress_edge cyc=%0d rd=%b wr=%b", c, src_rd_en, dst_wr_en);
                end
            end
            advance();
        end
        dst_almost_full = 1'b0;
    endtask

    task automatic test_wrap();
        int fed = 0;
        do_reset();
        for (int c = 0; c < 300; c++) begin
            while (fed < 260 && q[1].size() < 12) begin q[1].push_back(DW'($urandom)); fed++; end
            eval();
            n_vec++;
            if ({src_rd_en, dst_wr_en, grant, fwd_count} !== {m_rd, m_wr, 2'(m_g), 8'(m_fwd)} ||
                (m_wr && dst_data !== m_data)) begin
                n_bad++;
                $display("FAIL wrap cyc=%0d %s", c, obs_str());
            end
            advance();
        end
        n_vec++;
        if (fwd_count !== 8'd4) begin
            n_bad++;
            $display("FAIL wrap_total fwd=%0d exp 4", fwd_count);
        end
    endtask

    task automatic test_async_reset();
        bit hit = 0;
        do_reset();
        for (int i = 0; i < 2; i++) repeat (5) q[i].push_back(DW'($urandom));
        for (int c = 0; c < 10 && !hit; c++) begin
            eval();
            n_vec++;
            if ({src_rd_en, dst_wr_en, grant, fwd_count} !== {m_rd, m_wr, 2'(m_g), 8'(m_fwd)} ||
                (m_wr && dst_data !== m_data)) begin
                n_bad++;
                $display("FAIL areset_pre cyc=%0d %s", c, obs_str());
            end
            hit = (m_rd != 0);
            advance();
        end
        n_vec++;
        if (!hit) begin
            n_bad++;
            $display("FAIL areset_no_pop rd=%b exp nonzero", src_rd_en);
        end
        // Word popped last cycle is in flight; reset now must discard it.
        rst = 1'b0;
        #1;
        n_vec++;
        if ({src_rd_en, dst_wr_en, grant, fwd_count, dst_data} !== {4'b0, 1'b0, 2'd3, 8'd0, 4'h0}) begin
            n_bad++;
            $display("FAIL areset_now rd=%b wr=%b grant=%0d fwd=%0d data=%h exp 0000 0 3 0 0",
                     src_rd_en, dst_wr_en, grant, fwd_count, dst_data);
        end
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (dst_wr_en !== 1'b0) begin
                n_bad++;
                $display("FAIL areset_hold cyc=%0d wr=%b exp 0", c, dst_wr_en);
            end
        end
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            eval();
            n_vec++;
            if ({src_rd_en, dst_wr_en, grant, fwd_count} !== {m_rd, m_wr, 2'(m_g), 8'(m_fwd)} ||
                (m_wr && dst_data !== m_data)) begin
                n_bad++;
                $display("FAIL areset_post cyc=%0d %s", c, obs_str());
            end
            advance();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 4; i++) repeat ($urandom_range(6)) q[i].push_back(DW'($urandom));
        stall_rate = 25;
        push_rate  = 30;
        for (int c = 0; c < 400; c++) begin
            eval();
            n_vec++;
            if ({src_rd_en, dst_wr_en, grant, fwd_count} !== {m_rd, m_wr, 2'(m_g), 8'(m_fwd)} ||
                (m_wr && dst_data !== m_data)) begin
                n_bad++;
                $display("FAIL random cyc=%0d %s", c, obs_str());
            end
            advance();
        end
        stall_rate = 0;
        push_rate  = 0;
    endtask

    initial begin
        rst = 1'b0;
        dst_full = 1'b0;
        dst_almost_full = 1'b0;
        src_empty = '1;
        src_data = '0;
        n_vec = 0;
        n_bad = 0;
        test_reset();
        test_single_source();
        test_burst_rotation();
        test_back_pressure();
        test_wrap();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
